// File: rtl/vecmac_pkg.sv
// Shared widths and arithmetic helpers for the vecmac dot-product datapath.
// Pure functions/constants; no latency, no flow control.
package vecmac_pkg;

    // sat_add works on this fixed width; ACC_W and the tree sum width must not exceed it.
    localparam int SAT_ADD_W = 64;
    localparam int DEF_LANES = 8;
    localparam int DEF_DW    = 8;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    // Each lane operand is widened by one bit for signed/unsigned, so products are 2*DW+2 bits.
    function automatic int prod_w(input int dw);
        return 2 * dw + 2;
    endfunction

    function automatic int sum_w(input int dw, input int lanes);
        return prod_w(dw) + clog2(lanes);
    endfunction

    localparam int DEF_PROD_W = prod_w(DEF_DW);
    localparam int DEF_PW     = sum_w(DEF_DW, DEF_LANES);

    // Exact add, then range check against a signed acc_w-bit result.
    // Returns {ovf, result}; with sat=0 the caller keeps the low acc_w bits (wrap).
    function automatic logic [SAT_ADD_W:0] sat_add(
        input logic signed [SAT_ADD_W-1:0] a,
        input logic signed [SAT_ADD_W-1:0] b,
        input int                          acc_w,
        input logic                        sat
    );
        logic signed [SAT_ADD_W:0]   s;
        logic signed [SAT_ADD_W:0]   hi;
        logic signed [SAT_ADD_W-1:0] mx;
        logic signed [SAT_ADD_W-1:0] mn;
        logic        [SAT_ADD_W-1:0] r;
        logic                        ovf;
        s   = {a[SAT_ADD_W-1], a} + {b[SAT_ADD_W-1], b};
        hi  = s >>> (acc_w - 1);
        ovf = !((&hi) || !(|hi));
        mx  = (64'sd1 <<< (acc_w - 1)) - 64'sd1;
        mn  = -mx - 64'sd1;
        if (ovf && sat)
            r = s[SAT_ADD_W] ? mn : mx;
        else
            r = s[SAT_ADD_W-1:0];
        return {ovf, r};
    endfunction

endpackage

// File: rtl/vecmac_add_tree.sv
// Registered pairwise adder tree reducing LANES signed operands to one sum.
// Latency: clog2(LANES) cycles. Backpressure: whole tree and sideband freeze while en=0.
module vecmac_add_tree
    import vecmac_pkg::*;
#(
    parameter int LANES = 8,
    parameter int IW    = 18,
    parameter int OW    = 21,
    parameter int SB_W  = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   en,
    input  logic                   in_vld,
    input  logic [SB_W-1:0]        in_sb,
    input  logic [LANES*IW-1:0]    in_dat,
    output logic                   out_vld,
    output logic [SB_W-1:0]        out_sb,
    output logic signed [OW-1:0]   out_dat
);
    localparam int LVL = clog2(LANES);

    // Heap layout: node i sums operands 2i and 2i+1; indices >= LANES are the input leaves.
    logic signed [OW-1:0] node [1:LANES-1];
    logic signed [OW-1:0] opnd [2:2*LANES-1];
    logic [LVL-1:0]       vld_sr;
    logic [SB_W-1:0]      sb_sr [LVL];

    always_comb begin
        for (int i = 2; i < LANES; i++)
            opnd[i] = node[i];
        for (int i = 0; i < LANES; i++)
            opnd[LANES + i] = OW'($signed(in_dat[i*IW +: IW]));
    end

    always_ff @(posedge clk) begin
        if (en) begin
            for (int i = 1; i < LANES; i++)
                node[i] <= opnd[2*i] + opnd[2*i + 1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_sr <= '0;
            for (int i = 0; i < LVL; i++)
                sb_sr[i] <= '0;
        end else if (en) begin
            vld_sr[0] <= in_vld;
            sb_sr[0]  <= in_sb;
            for (int i = 1; i < LVL; i++) begin
                vld_sr[i] <= vld_sr[i-1];
                sb_sr[i]  <= sb_sr[i-1];
            end
        end
    end

    assign out_vld = vld_sr[LVL-1];
    assign out_sb  = sb_sr[LVL-1];
    assign out_dat = node[1];

endmodule

// File: rtl/vecmac_dot_acc.sv
// LANES x DW dot product per beat, accumulated over beats until in_last; signed/unsigned per beat.
// Latency: clog2(LANES)+2 cycles from last beat to out_valid; 1 beat/cycle throughput.
// Backpressure: global stall (in_ready = !out_valid || out_ready); every stage holds while stalled.
module vecmac_dot_acc
    import vecmac_pkg::*;
#(
    parameter int LANES = DEF_LANES,
    parameter int DW    = DEF_DW,
    parameter int ACC_W = 32,
    parameter int SAT   = 0,
    parameter int CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [LANES*DW-1:0]      in_a,
    input  logic [LANES*DW-1:0]      in_b,
    input  logic                     in_signed,
    input  logic                     in_last,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [ACC_W-1:0]  out_data,
    output logic [CNT_W-1:0]         out_beats,
    output logic                     out_ovf
);
    localparam int P_W = prod_w(DW);
    localparam int PW  = sum_w(DW, LANES);

    function automatic logic signed [DW:0] ext_lane(input logic [DW-1:0] v, input logic s);
        return {s & v[DW-1], v};
    endfunction

    logic adv;
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    // Multiply stage
    logic [LANES*P_W-1:0] prod;
    logic [LANES*P_W-1:0] m_prod;
    logic                 m_vld;
    logic                 m_last;

    always_comb begin
        prod = '0;
        for (int k = 0; k < LANES; k++)
            prod[k*P_W +: P_W] = P_W'(ext_lane(in_a[k*DW +: DW], in_signed))
                               * P_W'(ext_lane(in_b[k*DW +: DW], in_signed));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_vld  <= 1'b0;
            m_last <= 1'b0;
        end else if (adv) begin
            m_vld  <= in_valid;
            m_last <= in_last;
        end
    end

    always_ff @(posedge clk) begin
        if (adv)
            m_prod <= prod;
    end

    logic                 t_vld;
    logic                 t_last;
    logic signed [PW-1:0] t_sum;

    vecmac_add_tree #(
        .LANES (LANES),
        .IW    (P_W),
        .OW    (PW),
        .SB_W  (1)
    ) u_tree (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (adv),
        .in_vld  (m_vld),
        .in_sb   (m_last),
        .in_dat  (m_prod),
        .out_vld (t_vld),
        .out_sb  (t_last),
        .out_dat (t_sum)
    );

    // Accumulate stage; acc_first marks that the next beat opens a new vector.
    logic signed [ACC_W-1:0]     acc;
    logic [CNT_W-1:0]            acc_cnt;
    logic                        acc_ovf;
    logic                        acc_first;
    logic signed [SAT_ADD_W-1:0] a_base;
    logic [SAT_ADD_W:0]          a_sat;
    logic signed [ACC_W-1:0]     a_res;
    logic [CNT_W-1:0]            a_beats;
    logic                        a_ovf;
    logic [SAT_ADD_W-1:0]        unused_sat;

    always_comb begin
        a_base  = acc_first ? '0 : SAT_ADD_W'(acc);
        a_sat   = sat_add(a_base, SAT_ADD_W'(t_sum), ACC_W, SAT != 0);
        a_res   = a_sat[ACC_W-1:0];
        a_ovf   = a_sat[SAT_ADD_W] || (!acc_first && acc_ovf);
        a_beats = acc_first ? CNT_W'(1) : ((&acc_cnt) ? acc_cnt : acc_cnt + CNT_W'(1));
    end

    // Bits above ACC_W only matter inside sat_add.
    assign unused_sat = a_sat[SAT_ADD_W-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc       <= '0;
            acc_cnt   <= '0;
            acc_ovf   <= 1'b0;
            acc_first <= 1'b1;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_beats <= '0;
            out_ovf   <= 1'b0;
        end else if (adv) begin
            out_valid <= t_vld && t_last;
            if (t_vld && t_last) begin
                out_data  <= a_res;
                out_beats <= a_beats;
                out_ovf   <= a_ovf;
                acc_first <= 1'b1;
            end else if (t_vld) begin
                acc       <= a_res;
                acc_cnt   <= a_beats;
                acc_ovf   <= a_ovf;
                acc_first <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_vecmac_dot_acc.sv
// Directed bench for vecmac_dot_acc: default build plus two ACC_W=20 builds (saturate / wrap).
module tb_vecmac_dot_acc;
    logic               clk = 1'b0;
    logic               rst_n;
    logic               in_valid;
    logic [63:0]        in_a;
    logic [63:0]        in_b;
    logic               in_signed;
    logic               in_last;
    logic               out_ready;

    logic               in_ready, out_valid, out_ovf;
    logic signed [31:0] out_data;
    logic [15:0]        out_beats;
    logic               in_ready_s, out_valid_s, out_ovf_s;
    logic signed [19:0] out_data_s;
    logic [15:0]        out_beats_s;
    logic               in_ready_w, out_valid_w, out_ovf_w;
    logic signed [19:0] out_data_w;
    logic [15:0]        out_beats_w;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    vecmac_dot_acc dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_signed(in_signed), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_beats(out_beats), .out_ovf(out_ovf)
    );

    vecmac_dot_acc #(.ACC_W(20), .SAT(1)) dut_s (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_s),
        .in_a(in_a), .in_b(in_b), .in_signed(in_signed), .in_last(in_last),
        .out_valid(out_valid_s), .out_ready(out_ready), .out_data(out_data_s),
        .out_beats(out_beats_s), .out_ovf(out_ovf_s)
    );

    vecmac_dot_acc #(.ACC_W(20), .SAT(0)) dut_w (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_w),
        .in_a(in_a), .in_b(in_b), .in_signed(in_signed), .in_last(in_last),
        .out_valid(out_valid_w), .out_ready(out_ready), .out_data(out_data_w),
        .out_beats(out_beats_w), .out_ovf(out_ovf_w)
    );

    function automatic logic [63:0] rep(input logic [7:0] v);
        return {8{v}};
    endfunction

    function automatic logic [63:0] vec_a(input int i);
        logic [63:0] v;
        for (int k = 0; k < 8; k++) v[k*8 +: 8] = 8'(i + 17 * k);
        return v;
    endfunction

    function automatic logic [63:0] vec_b(input int i);
        logic [63:0] v;
        for (int k = 0; k < 8; k++) v[k*8 +: 8] = 8'(200 - 3 * i + 5 * k);
        return v;
    endfunction

    function automatic logic signed [31:0] dot(input logic [63:0] a, input logic [63:0] b, input logic s);
        int acc;
        int x;
        int y;
        acc = 0;
        for (int k = 0; k < 8; k++) begin
            x = s ? int'($signed(a[k*8 +: 8])) : int'(a[k*8 +: 8]);
            y = s ? int'($signed(b[k*8 +: 8])) : int'(b[k*8 +: 8]);
            acc += x * y;
        end
        return acc;
    endfunction

    task automatic send_beat(input logic [63:0] a, input logic [63:0] b, input logic s, input logic l);
        @(negedge clk);
        in_valid = 1'b1; in_a = a; in_b = b; in_signed = s; in_last = l;
        #1;
        for (int c = 0; c < 50 && !in_ready; c++) begin
            @(negedge clk);
            #1;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_out(output int n);
        n = -1;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            #1;
            if (out_valid) begin
                n = c;
                break;
            end
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        #1;
        total++;
        if (out_valid !== 1'b0 || out_valid_s !== 1'b0 || out_valid_w !== 1'b0) begin
            bad++; $display("FAIL reset_valid got=%b%b%b want=000", out_valid, out_valid_s, out_valid_w);
        end
        total++;
        if (out_data !== 32'sd0 || out_beats !== 16'd0 || out_ovf !== 1'b0) begin
            bad++; $display("FAIL reset_outputs got data=%0d beats=%0d ovf=%b want 0/0/0", out_data, out_beats, out_ovf);
        end
        total++;
        if (in_ready !== 1'b1 || in_ready_s !== 1'b1 || in_ready_w !== 1'b1) begin
            bad++; $display("FAIL reset_in_ready got=%b%b%b want=111", in_ready, in_ready_s, in_ready_w);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            bad++; $display("FAIL post_reset got valid=%b ready=%b want 0/1", out_valid, in_ready);
        end
    endtask

    task automatic test_single_unsigned();
        int n;
        send_beat(rep(8'hFF), rep(8'hFF), 1'b0, 1'b1);
        wait_out(n);
        total++;
        if (n !== 5) begin bad++; $display("FAIL t1_latency got=%0d want=5", n); end
        total++;
        if (out_data !== 32'sd520200 || out_beats !== 16'd1 || out_ovf !== 1'b0) begin
            bad++; $display("FAIL t1_result got=%0d/%0d/%b want=520200/1/0", out_data, out_beats, out_ovf);
        end
        total++;
        if (out_data_s !== 20'sd520200 || out_ovf_s !== 1'b0 || out_data_w !== 20'sd520200 || out_ovf_w !== 1'b0) begin
            bad++; $display("FAIL t1_acc20 got=%0d/%b %0d/%b want=520200/0", out_data_s, out_ovf_s, out_data_w, out_ovf_w);
        end
        @(negedge clk);
        #1;
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL t1_single_result got valid=%b want=0", out_valid); end
    endtask

    task automatic test_single_signed();
        int n;
        send_beat(rep(8'h80), rep(8'h7F), 1'b1, 1'b1);
        wait_out(n);
        total++;
        if (n !== 5) begin bad++; $display("FAIL t2_latency got=%0d want=5", n); end
        total++;
        if (out_data !== -32'sd130048 || out_beats !== 16'd1 || out_ovf !== 1'b0) begin
            bad++; $display("FAIL t2_result got=%0d/%0d/%b want=-130048/1/0", out_data, out_beats, out_ovf);
        end
    endtask

    task automatic test_multi_beat();
        int n;
        for (int i = 0; i < 4; i++) begin
            send_beat(rep(8'h01), rep(8'h02), 1'b0, i == 3);
            if (i < 3) repeat (2) @(negedge clk);
        end
        wait_out(n);
        total++;
        if (n !== 5) begin bad++; $display("FAIL t3_latency got=%0d want=5", n); end
        total++;
        if (out_data !== 32'sd64 || out_beats !== 16'd4 || out_ovf !== 1'b0) begin
            bad++; $display("FAIL t3_result got=%0d/%0d/%b want=64/4/0", out_data, out_beats, out_ovf);
        end
    endtask

    task automatic test_back_to_back();
        logic signed [31:0] exp_q[$];
        logic signed [31:0] held_dat;
        logic signed [31:0] e;
        logic               held;
        int                 sent, got, cyc, stall_cyc;
        sent = 0; got = 0; cyc = 0; stall_cyc = 0; held = 1'b0; held_dat = '0;
        while (got < 100 && cyc < 2000) begin
            @(negedge clk);
            out_ready = !((cyc >= 20 && cyc < 30) || (cyc >= 60 && cyc < 70));
            if (sent < 100) begin
                in_valid = 1'b1; in_a = vec_a(sent); in_b = vec_b(sent);
                in_signed = (sent % 3 == 0); in_last = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (held) begin
                total++;
                if (out_valid !== 1'b1 || out_data !== held_dat) begin
                    bad++; $display("FAIL t4_hold cyc=%0d got=%b/%0d want=1/%0d", cyc, out_valid, out_data, held_dat);
                end
            end
            held = 1'b0;
            if (out_valid) begin
                if (!out_ready) begin
                    stall_cyc++;
                    held = 1'b1;
                    held_dat = out_data;
                    total++;
                    if (in_ready !== 1'b0) begin bad++; $display("FAIL t4_in_ready cyc=%0d got=%b want=0", cyc, in_ready); end
                end else begin
                    total++;
                    if (exp_q.size() == 0) begin
                        bad++; $display("FAIL t4_extra got=%0d want=none", out_data);
                    end else begin
                        e = exp_q.pop_front();
                        if (out_data !== e || out_beats !== 16'd1) begin
                            bad++; $display("FAIL t4_result idx=%0d got=%0d/%0d want=%0d/1", got, out_data, out_beats, e);
                        end
                    end
                    got++;
                end
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(dot(in_a, in_b, in_signed));
                sent++;
            end
            cyc++;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        total++;
        if (got !== 100 || sent !== 100 || exp_q.size() !== 0) begin
            bad++; $display("FAIL t4_count got=%0d sent=%0d left=%0d want=100/100/0", got, sent, exp_q.size());
        end
        total++;
        if (stall_cyc !== 20) begin bad++; $display("FAIL t4_stall_cycles got=%0d want=20", stall_cyc); end
    endtask

    task automatic test_overflow();
        int n;
        for (int i = 0; i < 3; i++)
            send_beat(rep(8'hFF), rep(8'hFF), 1'b0, i == 2);
        wait_out(n);
        total++;
        if (n !== 5) begin bad++; $display("FAIL t5_latency got=%0d want=5", n); end
        total++;
        if (out_data_s !== 20'sd524287 || out_ovf_s !== 1'b1 || out_beats_s !== 16'd3) begin
            bad++; $display("FAIL t5_sat got=%0d/%b/%0d want=524287/1/3", out_data_s, out_ovf_s, out_beats_s);
        end
        total++;
        if (out_data_w !== 20'sd512024 || out_ovf_w !== 1'b1 || out_beats_w !== 16'd3) begin
            bad++; $display("FAIL t5_wrap got=%0d/%b/%0d want=512024/1/3", out_data_w, out_ovf_w, out_beats_w);
        end
        total++;
        if (out_data !== 32'sd1560600 || out_ovf !== 1'b0) begin
            bad++; $display("FAIL t5_acc32 got=%0d/%b want=1560600/0", out_data, out_ovf);
        end
        send_beat(rep(8'h01), rep(8'h01), 1'b0, 1'b1);
        wait_out(n);
        total++;
        if (out_ovf_s !== 1'b0 || out_ovf_w !== 1'b0 || out_data_s !== 20'sd8 || out_data_w !== 20'sd8) begin
            bad++; $display("FAIL t5_rearm got=%0d/%b %0d/%b want=8/0", out_data_s, out_ovf_s, out_data_w, out_ovf_w);
        end
    endtask

    task automatic test_reset_mid_vector();
        int n;
        int seen;
        send_beat(rep(8'd200), rep(8'd200), 1'b0, 1'b0);
        send_beat(rep(8'd200), rep(8'd200), 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== 32'sd0) begin
            bad++; $display("FAIL t6_in_reset got=%b/%b/%0d want=0/1/0", out_valid, in_ready, out_data);
        end
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (12) begin
            @(negedge clk);
            #1;
            if (out_valid) seen++;
        end
        total++;
        if (seen !== 0) begin bad++; $display("FAIL t6_no_output got=%0d want=0", seen); end
        send_beat(rep(8'h03), rep(8'h03), 1'b0, 1'b1);
        wait_out(n);
        total++;
        if (n !== 5 || out_data !== 32'sd72 || out_beats !== 16'd1 || out_ovf !== 1'b0) begin
            bad++; $display("FAIL t6_next got lat=%0d %0d/%0d/%b want=5 72/1/0", n, out_data, out_beats, out_ovf);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0;
        in_signed = 1'b0; in_last = 1'b0; out_ready = 1'b1;
        test_reset();
        test_single_unsigned();
        test_single_signed();
        test_multi_beat();
        test_back_to_back();
        test_overflow();
        test_reset_mid_vector();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
